// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the cpu.
// State encoding and instruction word geometry.
package imem_loader_pkg;

   localparam int INSTR_W        = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared, so reset leaves the program image in place.
module imem_array
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into instruction words, then releases
// the cpu and serves the word addressed by its pc.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   input  logic               load_done,
   input  logic               reload,
   input  logic [31:0]        pc,
   output logic [INSTR_W-1:0] instruction,
   output logic               cpu_rst_n,
   output logic [ADDR_W:0]    word_count,
   output logic               err
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int ASM_W = INSTR_W - 8;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W:0]  FULL = (ADDR_W+1)'(DEPTH);

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   byte_cnt;
   logic [CNT_W-1:0]   cnt_nx;
   logic [ASM_W-1:0]   asm_q;
   logic [ASM_W-1:0]   asm_nx;
   logic [ADDR_W:0]    wc;
   logic [ADDR_W:0]    wc_nx;
   logic               err_q;
   logic               err_nx;
   logic               cpu_q;

   logic               full;
   logic               xfer;
   logic               last;
   logic               we;
   logic               pc_ok;
   logic [INSTR_W-1:0] rdata;

   assign full       = (wc == FULL);
   assign byte_ready = (state == LOAD) && !full;
   assign xfer       = byte_valid && byte_ready;
   assign last       = (byte_cnt == LAST);

   // A reload in the same cycle abandons the byte, so no write either.
   assign we = xfer && last && !reload;

   assign pc_ok = (pc[1:0] == 2'b00) && (pc[31:2] < 30'(wc));

   imem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (wc[ADDR_W-1:0]),
      .wdata ({asm_q, byte_data}),
      .raddr (pc[ADDR_W+1:2]),
      .rdata (rdata)
   );

   assign instruction = pc_ok ? rdata : '0;
   assign word_count  = wc;
   assign err         = err_q;
   assign cpu_rst_n   = cpu_q;

   always_comb begin
      state_nx = state;
      cnt_nx   = byte_cnt;
      asm_nx   = asm_q;
      wc_nx    = wc;
      err_nx   = err_q;
      unique case (state)
         LOAD: begin
            if (xfer) begin
               if (last) begin
                  cnt_nx = '0;
                  asm_nx = '0;
                  wc_nx  = wc + 1'b1;
               end else begin
                  cnt_nx = byte_cnt + 1'b1;
                  asm_nx = {asm_q[ASM_W-9:0], byte_data};
               end
            end
            if (byte_valid && full) begin
               err_nx = 1'b1;
            end
            // Partial check sees the count after this cycle's byte.
            if (load_done) begin
               state_nx = RUN;
               if (cnt_nx != '0) begin
                  err_nx = 1'b1;
                  cnt_nx = '0;
                  asm_nx = '0;
               end
            end
         end
         RUN: begin
            if (!pc_ok) begin
               err_nx = 1'b1;
            end
         end
      endcase
      if (reload) begin
         state_nx = LOAD;
         cnt_nx   = '0;
         asm_nx   = '0;
         wc_nx    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD;
         byte_cnt <= '0;
         asm_q    <= '0;
         wc       <= '0;
         err_q    <= 1'b0;
         cpu_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         byte_cnt <= cnt_nx;
         asm_q    <= asm_nx;
         wc       <= wc_nx;
         err_q    <= err_nx;
         cpu_q    <= (state_nx == RUN);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, partial word, overflow,
// bad pc, reload and asynchronous reset scenarios.
module tb_imem_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst_n;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              load_done;
   logic              reload;
   logic [31:0]       pc;
   logic [31:0]       instruction;
   logic              cpu_rst_n;
   logic [ADDR_W:0]   word_count;
   logic              err;

   int errors = 0;
   int checks = 0;

   imem_loader #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .load_done   (load_done),
      .reload      (reload),
      .pc          (pc),
      .instruction (instruction),
      .cpu_rst_n   (cpu_rst_n),
      .word_count  (word_count),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      byte_valid = 1'b0;
      load_done = 1'b0;
      reload = 1'b0;
      pc = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b, input logic done);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data = b;
      load_done = done;
      @(negedge clk);
      byte_valid = 1'b0;
      load_done = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      byte_valid = 1'b0;
      byte_data = 8'h0;
      load_done = 1'b0;
      reload = 1'b0;
      pc = 32'h0;
      #12;
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", byte_ready); end
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu got=%b want=0", cpu_rst_n); end
      checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL reset_wc got=%0d want=0", word_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", instruction); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_load();
      push(8'h10, 1'b0);
      push(8'h20, 1'b0);
      push(8'h30, 1'b0);
      push(8'h40, 1'b0);
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'h10203040) begin errors++; $display("FAIL basic_latency got=%h want=10203040", instruction); end
      push(8'hA1, 1'b0);
      push(8'hB2, 1'b0);
      push(8'hC3, 1'b0);
      push(8'hD4, 1'b0);
      checks++; if (word_count !== 9'd2) begin errors++; $display("FAIL basic_wc got=%0d want=2", word_count); end
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL basic_cpu_load got=%b want=0", cpu_rst_n); end
      pulse_done();
      checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL basic_cpu_run got=%b want=1", cpu_rst_n); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_run got=%b want=0", byte_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", err); end
      pc = 32'h4; #1;
      checks++; if (instruction !== 32'hA1B2C3D4) begin errors++; $display("FAIL basic_pc4 got=%h want=a1b2c3d4", instruction); end
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'h10203040) begin errors++; $display("FAIL basic_pc0 got=%h want=10203040", instruction); end
   endtask

   task automatic test_done_with_last();
      pulse_reload();
      checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL dwl_reload_wc got=%0d want=0", word_count); end
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL dwl_reload_cpu got=%b want=0", cpu_rst_n); end
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b1);
      checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL dwl_wc got=%0d want=1", word_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dwl_err got=%b want=0", err); end
      checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL dwl_cpu got=%b want=1", cpu_rst_n); end
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'h11223344) begin errors++; $display("FAIL dwl_pc0 got=%h want=11223344", instruction); end
      pulse_done();
      checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL dwl_done_ignored_wc got=%0d want=1", word_count); end
      checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL dwl_done_ignored_cpu got=%b want=1", cpu_rst_n); end
   endtask

   task automatic test_partial();
      pulse_reload();
      for (int i = 1; i <= 6; i++) begin
         push(8'(i), 1'b0);
      end
      pulse_done();
      checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL partial_wc got=%0d want=1", word_count); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL partial_err got=%b want=1", err); end
      checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL partial_cpu got=%b want=1", cpu_rst_n); end
      pc = 32'h4; #1;
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL partial_pc4 got=%h want=0", instruction); end
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'h01020304) begin errors++; $display("FAIL partial_pc0 got=%h want=01020304", instruction); end
   endtask

   task automatic test_bad_pc();
      do_reset();
      push(8'hDE, 1'b0);
      push(8'hAD, 1'b0);
      push(8'hBE, 1'b0);
      push(8'hEF, 1'b1);
      pc = 32'h2; #1;
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL badpc_instr got=%h want=0", instruction); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL badpc_err_before got=%b want=0", err); end
      @(posedge clk); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL badpc_err_after got=%b want=1", err); end
      pc = 32'h0;
      pulse_reload();
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL badpc_reload_cpu got=%b want=0", cpu_rst_n); end
      checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL badpc_reload_wc got=%0d want=0", word_count); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL badpc_reload_ready got=%b want=1", byte_ready); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL badpc_err_kept got=%b want=1", err); end
   endtask

   task automatic test_overflow();
      int acc;
      int full_seen;
      acc = 0;
      full_seen = 0;
      do_reset();
      byte_valid = 1'b1;
      for (int cyc = 0; cyc < 1100 && full_seen < 4; cyc++) begin
         byte_data = acc[7:0];
         #1;
         if (byte_ready) begin
            acc++;
         end else begin
            full_seen++;
            if (full_seen == 1) begin
               checks++; if (acc != DEPTH*4) begin errors++; $display("FAIL ovf_accepted got=%0d want=%0d", acc, DEPTH*4); end
               checks++; if (word_count !== 9'd256) begin errors++; $display("FAIL ovf_wc got=%0d want=256", word_count); end
               checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got=%b want=0", err); end
            end
         end
         @(negedge clk);
      end
      byte_valid = 1'b0;
      checks++; if (full_seen != 4) begin errors++; $display("FAIL ovf_timeout got=%0d want=4", full_seen); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b want=1", err); end
      checks++; if (word_count !== 9'd256) begin errors++; $display("FAIL ovf_wc_final got=%0d want=256", word_count); end
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'h00010203) begin errors++; $display("FAIL ovf_mem0 got=%h want=00010203", instruction); end
      pc = 32'h4; #1;
      checks++; if (instruction !== 32'h04050607) begin errors++; $display("FAIL ovf_mem1 got=%h want=04050607", instruction); end
      pc = 32'd1024; #1;
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL ovf_beyond got=%h want=0", instruction); end
      pc = 32'h0;
      pulse_done();
      checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL ovf_cpu got=%b want=1", cpu_rst_n); end
      pc = 32'd1020; #1;
      checks++; if (instruction !== 32'hFCFDFEFF) begin errors++; $display("FAIL ovf_last got=%h want=fcfdfeff", instruction); end
      pc = 32'h0;
   endtask

   task automatic test_async_reset();
      pulse_reload();
      push(8'h55, 1'b0);
      push(8'h66, 1'b0);
      push(8'h77, 1'b0);
      push(8'h88, 1'b0);
      push(8'h99, 1'b0);
      push(8'hAA, 1'b0);
      checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL arst_wc_before got=%0d want=1", word_count); end
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL arst_wc got=%0d want=0", word_count); end
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL arst_cpu got=%b want=0", cpu_rst_n); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b want=1", byte_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got=%b want=0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      push(8'hC1, 1'b0);
      push(8'hC2, 1'b0);
      push(8'hC3, 1'b0);
      push(8'hC4, 1'b1);
      checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL arst_reload_wc got=%0d want=1", word_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_no_partial got=%b want=0", err); end
      pc = 32'h0; #1;
      checks++; if (instruction !== 32'hC1C2C3C4) begin errors++; $display("FAIL arst_word got=%h want=c1c2c3c4", instruction); end
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL arst_run_cpu got=%b want=0", cpu_rst_n); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_done_with_last();
      test_partial();
      test_bad_pc();
      test_overflow();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
